// File: rtl/tmds_channel_sequencer.sv
// ============================================================================
// Module  : tmds_channel_sequencer (with helper tm_choice)
// Brief   : Per-channel TMDS sequencer: control tokens, guard bands, video.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tm_choice (
    input  logic [7:0] i_data,
    output logic [8:0] o_qm
);
    logic [3:0] w_ones;
    logic       w_use_xnor;

    always_comb begin
        w_ones = '0;
        for (int i = 0; i < 8; i++) begin
            w_ones = w_ones + {3'b000, i_data[i]};
        end
        w_use_xnor = (w_ones > 4'd4) || ((w_ones == 4'd4) && !i_data[0]);
        o_qm       = '0;
        o_qm[0]    = i_data[0];
        for (int i = 1; i < 8; i++) begin
            o_qm[i] = w_use_xnor ? ~(o_qm[i-1] ^ i_data[i]) : (o_qm[i-1] ^ i_data[i]);
        end
        o_qm[8] = ~w_use_xnor;
    end
endmodule

module tmds_channel_sequencer #(
    parameter int         GUARD_LEN  = 2,
    parameter logic [9:0] GUARD_WORD = 10'b1011001100
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] data_in,
    input  logic [1:0] control_in,
    input  logic       ve_in,
    output logic [9:0] tmds_out
);
    localparam logic [1:0] c_CLS_CTRL  = 2'd0;
    localparam logic [1:0] c_CLS_GUARD = 2'd1;
    localparam logic [1:0] c_CLS_VIDEO = 2'd2;
    localparam logic [9:0] c_TOK_00    = 10'b1101010100;
    localparam logic [9:0] c_TOK_01    = 10'b0010101011;
    localparam logic [9:0] c_TOK_10    = 10'b0101010100;
    localparam logic [9:0] c_TOK_11    = 10'b1010101011;

    // Word layout: {valid, ve, control[1:0], data[7:0]}; valid marks words that
    // really came from the input, so reset-filled slots never trigger a guard.
    logic [11:0] w_cur;
    logic        w_win_ve;

    generate
        if (GUARD_LEN > 0) begin : g_delay_line
            logic [GUARD_LEN-1:0][11:0] sr_q, sr_d;

            always_comb begin
                sr_d[0] = {1'b1, ve_in, control_in, data_in};
                for (int i = 1; i < GUARD_LEN; i++) begin
                    sr_d[i] = sr_q[i-1];
                end
            end

            always_ff @(posedge clk_in) begin
                if (rst_in) sr_q <= '0;
                else        sr_q <= sr_d;
            end

            always_comb begin
                w_win_ve = ve_in;
                for (int i = 0; i < GUARD_LEN - 1; i++) begin
                    w_win_ve = w_win_ve | sr_q[i][10];
                end
            end

            assign w_cur = sr_q[GUARD_LEN-1];
        end else begin : g_no_delay
            assign w_cur    = {1'b1, ve_in, control_in, data_in};
            assign w_win_ve = 1'b0;
        end
    endgenerate

    logic [1:0] cls_q, cls_d;
    logic [1:0] ctrl_q, ctrl_d;
    logic [8:0] qm_q, qm_d;

    tm_choice u_tm_choice (
        .i_data (w_cur[7:0]),
        .o_qm   (qm_d)
    );

    always_comb begin
        ctrl_d = w_cur[9:8];
        if (w_cur[10])                  cls_d = c_CLS_VIDEO;
        else if (w_win_ve && w_cur[11]) cls_d = c_CLS_GUARD;
        else                            cls_d = c_CLS_CTRL;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cls_q  <= c_CLS_CTRL;
            ctrl_q <= 2'b00;
            qm_q   <= '0;
        end else begin
            cls_q  <= cls_d;
            ctrl_q <= ctrl_d;
            qm_q   <= qm_d;
        end
    end

    logic [9:0]        out_q, out_d;
    logic signed [4:0] cnt_q, cnt_d;
    logic [3:0]        w_n1;
    logic signed [5:0] w_diff6;
    logic signed [4:0] w_diff;

    always_comb begin
        w_n1 = '0;
        for (int i = 0; i < 8; i++) begin
            w_n1 = w_n1 + {3'b000, qm_q[i]};
        end
        // n1 - n0 = 2*n1 - 8, always within -8..+8
        w_diff6 = $signed({1'b0, w_n1, 1'b0}) - 6'sd8;
        w_diff  = w_diff6[4:0];
        out_d   = c_TOK_00;
        cnt_d   = '0;
        case (cls_q)
            c_CLS_VIDEO: begin
                if ((cnt_q == 5'sd0) || (w_n1 == 4'd4)) begin
                    out_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
                    cnt_d = qm_q[8] ? (cnt_q + w_diff) : (cnt_q - w_diff);
                end else if (((cnt_q > 5'sd0) && (w_n1 > 4'd4)) ||
                             ((cnt_q < 5'sd0) && (w_n1 < 4'd4))) begin
                    out_d = {1'b1, qm_q[8], ~qm_q[7:0]};
                    cnt_d = cnt_q - w_diff + (qm_q[8] ? 5'sd2 : 5'sd0);
                end else begin
                    out_d = {1'b0, qm_q[8], qm_q[7:0]};
                    cnt_d = cnt_q + w_diff - (qm_q[8] ? 5'sd0 : 5'sd2);
                end
            end
            c_CLS_GUARD: out_d = GUARD_WORD;
            default: begin
                case (ctrl_q)
                    2'b00:   out_d = c_TOK_00;
                    2'b01:   out_d = c_TOK_01;
                    2'b10:   out_d = c_TOK_10;
                    default: out_d = c_TOK_11;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            out_q <= c_TOK_00;
            cnt_q <= '0;
        end else begin
            out_q <= out_d;
            cnt_q <= cnt_d;
        end
    end

    assign tmds_out = out_q;

endmodule

`default_nettype wire

// File: tb/tb_tmds_channel_sequencer.sv
// ============================================================================
// Module  : tb_tmds_channel_sequencer
// Brief   : Directed table vectors plus reference-model sequences.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tmds_channel_sequencer;
    localparam int         G   = 2;
    localparam int         L   = G + 2;
    localparam int         MAXN = 2048;
    localparam logic [9:0] GW  = 10'b1011001100;
    localparam logic [9:0] T00 = 10'b1101010100;
    localparam logic [9:0] T01 = 10'b0010101011;
    localparam logic [9:0] T10 = 10'b0101010100;
    localparam logic [9:0] T11 = 10'b1010101011;
    localparam logic [9:0] V0  = 10'b0100000000;
    localparam logic [9:0] V1  = 10'b1111111111;
    localparam logic [9:0] VFF = 10'b0011111111;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic [1:0] control_in = 2'b00;
    logic       ve_in = 1'b0;
    logic [9:0] tmds_out;

    tmds_channel_sequencer #(.GUARD_LEN(G), .GUARD_WORD(GW)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .data_in    (data_in),
        .control_in (control_in),
        .ve_in      (ve_in),
        .tmds_out   (tmds_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic       ve;
        logic [1:0] ctrl;
        logic [7:0] data;
        logic [9:0] exp;
    } vec_t;

    vec_t       tbl [0:27];
    logic       s_ve   [0:MAXN-1];
    logic [1:0] s_ctrl [0:MAXN-1];
    logic [7:0] s_data [0:MAXN-1];
    logic [9:0] obs    [0:MAXN-1];
    int         checks = 0;
    int         failures = 0;

    function automatic vec_t mk(input logic ve, input logic [1:0] c,
                                input logic [7:0] d, input logic [9:0] e);
        vec_t v;
        v.ve = ve; v.ctrl = c; v.data = d; v.exp = e;
        return v;
    endfunction

    function automatic int ones8(input logic [7:0] v);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic logic [8:0] tm(input logic [7:0] d);
        logic [8:0] q;
        logic       x;
        x    = (ones8(d) > 4) || (ones8(d) == 4 && d[0] == 1'b0);
        q    = '0;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = x ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = ~x;
        return q;
    endfunction

    function automatic logic [7:0] dec(input logic [9:0] w);
        logic [7:0] x, d;
        x    = w[9] ? ~w[7:0] : w[7:0];
        d    = '0;
        d[0] = x[0];
        for (int i = 1; i < 8; i++) d[i] = w[8] ? (x[i] ^ x[i-1]) : ~(x[i] ^ x[i-1]);
        return d;
    endfunction

    function automatic logic [9:0] token(input logic [1:0] c);
        case (c)
            2'b00:   return T00;
            2'b01:   return T01;
            2'b10:   return T10;
            default: return T11;
        endcase
    endfunction

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step(input logic ve, input logic [1:0] c, input logic [7:0] d,
                        output logic [9:0] o);
        @(negedge clk_in);
        rst_in = 1'b0; ve_in = ve; control_in = c; data_in = d;
        @(posedge clk_in);
        #1 o = tmds_out;
    endtask

    task automatic do_reset(input int cyc);
        for (int c = 0; c < cyc; c++) begin
            @(negedge clk_in);
            rst_in = 1'b1;
            @(posedge clk_in);
            #1;
            if (c == 0) check("reset_out", tmds_out, T00);
        end
    endtask

    task automatic run_seq(input int n);
        logic [9:0] o;
        for (int i = 0; i < n; i++) begin
            step(s_ve[i], s_ctrl[i], s_data[i], o);
            obs[i] = o;
        end
    endtask

    // Reference: output j carries input j-(L-1); earlier slots show the reset token.
    task automatic check_model(input int n, input string tag);
        int         cnt, k, n1, n0;
        logic       g;
        logic [8:0] qm;
        logic [9:0] e;
        cnt = 0;
        for (int j = 0; j < n; j++) begin
            k = j - (L - 1);
            if (k < 0) begin
                e = T00;
            end else if (s_ve[k]) begin
                qm = tm(s_data[k]);
                n1 = ones8(qm[7:0]);
                n0 = 8 - n1;
                if (cnt == 0 || n1 == n0) begin
                    e = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
                    cnt += qm[8] ? (n1 - n0) : (n0 - n1);
                end else if ((cnt > 0 && n1 > n0) || (cnt < 0 && n0 > n1)) begin
                    e = {1'b1, qm[8], ~qm[7:0]};
                    cnt += (qm[8] ? 2 : 0) + (n0 - n1);
                end else begin
                    e = {1'b0, qm[8], qm[7:0]};
                    cnt += (n1 - n0) - (qm[8] ? 0 : 2);
                end
                check({tag, "_decode"}, {2'b00, dec(obs[j])}, {2'b00, s_data[k]});
            end else begin
                g = 1'b0;
                for (int m = 1; m <= G; m++) if (k + m < n && s_ve[k + m]) g = 1'b1;
                e   = g ? GW : token(s_ctrl[k]);
                cnt = 0;
            end
            check(tag, obs[j], e);
        end
    endtask

    initial begin
        int n, px, len;
        logic [9:0] o;

        tbl[0]  = mk(1'b0, 2'b00, 8'h00, T00);
        tbl[1]  = mk(1'b0, 2'b01, 8'h00, T01);
        tbl[2]  = mk(1'b0, 2'b10, 8'h00, T10);
        tbl[3]  = mk(1'b0, 2'b11, 8'h00, T11);
        for (int i = 4; i < 12; i++) tbl[i] = mk(1'b0, 2'b00, 8'h00, T00);
        tbl[12] = mk(1'b0, 2'b00, 8'h00, GW);
        tbl[13] = mk(1'b0, 2'b00, 8'h00, GW);
        tbl[14] = mk(1'b1, 2'b00, 8'h00, V0);   // cnt -8
        tbl[15] = mk(1'b1, 2'b00, 8'h00, V1);   // cnt +2
        tbl[16] = mk(1'b1, 2'b00, 8'h00, V0);   // cnt -6
        tbl[17] = mk(1'b1, 2'b00, 8'h00, V1);   // cnt +4
        tbl[18] = mk(1'b0, 2'b00, 8'h00, T00);
        tbl[19] = mk(1'b0, 2'b01, 8'h00, GW);
        tbl[20] = mk(1'b0, 2'b00, 8'h00, GW);
        tbl[21] = mk(1'b1, 2'b00, 8'h00, V0);   // tally cleared by gap
        tbl[22] = mk(1'b0, 2'b11, 8'h00, GW);
        tbl[23] = mk(1'b1, 2'b00, 8'h00, V0);
        tbl[24] = mk(1'b1, 2'b00, 8'hFF, VFF);  // cnt -8 -> -2
        tbl[25] = mk(1'b0, 2'b00, 8'h00, T00);
        tbl[26] = mk(1'b0, 2'b10, 8'h00, T10);
        tbl[27] = mk(1'b0, 2'b10, 8'h00, T10);

        do_reset(3);
        for (int i = 0; i < 28; i++) begin
            step(tbl[i].ve, tbl[i].ctrl, tbl[i].data, o);
            obs[i] = o;
        end
        for (int i = 28; i < 28 + L - 1; i++) begin
            step(1'b0, 2'b00, 8'h00, o);
            obs[i] = o;
        end
        for (int i = 0; i < L - 1; i++) check("table_fill", obs[i], T00);
        for (int i = 0; i < 28; i++) check($sformatf("table_row%0d", i), obs[i + L - 1], tbl[i].exp);

        // Video straight out of reset: no guard for slots the line never saw.
        do_reset(1);
        for (int i = 0; i < 6; i++) begin
            s_ve[i] = 1'b1; s_ctrl[i] = 2'b00; s_data[i] = 8'(i * 37 + 5);
        end
        for (int i = 6; i < 10; i++) begin
            s_ve[i] = 1'b0; s_ctrl[i] = 2'b01; s_data[i] = 8'h00;
        end
        run_seq(10);
        check_model(10, "first_cycle_video");

        // Reset pulse in the middle of a video burst.
        for (int i = 0; i < 11; i++) begin
            s_ve[i] = (i >= 3); s_ctrl[i] = 2'b10; s_data[i] = 8'(i * 91 + 3);
        end
        do_reset(1);
        run_seq(11);
        check_model(11, "pre_reset");
        do_reset(1);
        for (int i = 0; i < 8; i++) begin
            s_ve[i] = (i < 3); s_ctrl[i] = 2'b00; s_data[i] = 8'h00;
        end
        run_seq(8);
        check_model(8, "post_reset");

        // Random bursts with short gaps.
        do_reset(1);
        n  = 0;
        px = 0;
        while (px < 1000) begin
            len = int'($urandom_range(0, 6));
            for (int i = 0; i < len; i++) begin
                s_ve[n] = 1'b0; s_ctrl[n] = 2'($urandom_range(0, 3)); s_data[n] = 8'($urandom);
                n++;
            end
            len = int'($urandom_range(1, 40));
            if (len > 1000 - px) len = 1000 - px;
            for (int i = 0; i < len; i++) begin
                s_ve[n] = 1'b1; s_ctrl[n] = 2'($urandom_range(0, 3)); s_data[n] = 8'($urandom);
                n++;
            end
            px += len;
        end
        for (int i = 0; i < L; i++) begin
            s_ve[n] = 1'b0; s_ctrl[n] = 2'b00; s_data[n] = 8'h00;
            n++;
        end
        run_seq(n);
        check_model(n, "random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
